sweep_ctrl: RTL

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_pkg.sv | 6 +
 rtl/updown_cnt.sv | 17 +
 rtl/sweep_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding and width constants for the sweep controller
package sweep_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;
  localparam int WIDTH_DEF = 3;
  localparam int SWEEPS_W = 4;
endpackage

// File: rtl/updown_cnt.sv
// updown_cnt: loadable up/down counter; load wins over count enable
module updown_cnt import sweep_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= load_val;
    else if (en) q <= up ? q + 1'b1 : q - 1'b1;
endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: runs a counter lo->hi->lo for a latched number of round trips
module sweep_ctrl import sweep_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    lo,
  input  logic [WIDTH-1:0]    hi,
  input  logic [SWEEPS_W-1:0] sweeps,
  input  logic                hold,
  output logic [WIDTH-1:0]    q,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic                err
);
  state_t state;
  logic [WIDTH-1:0] lo_r, hi_r;
  logic [SWEEPS_W-1:0] rem;
  logic accept, run, at_hi, at_lo, last, en, up;
  always_comb begin
    accept = state == IDLE && start && lo < hi && sweeps != '0;
    run = (state == UP || state == DOWN) && !hold;
    at_hi = q == hi_r;
    at_lo = q == lo_r;
    last = rem == SWEEPS_W'(1);
    // the final arrival at lo parks the counter there for DONE
    en = run && !(state == DOWN && at_lo && last);
    up = state == UP ? !at_hi : at_lo;
  end
  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .load(accept), .load_val(lo), .en(en), .up(up), .q(q)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      lo_r <= '0;
      hi_r <= '0;
      rem <= '0;
      dir <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= state == IDLE && start && !accept;
      case (state)
        IDLE: if (accept) begin
          lo_r <= lo;
          hi_r <= hi;
          rem <= sweeps;
          dir <= 1'b1;
          busy <= 1'b1;
          state <= UP;
        end
        UP: if (!hold && at_hi) begin
          dir <= 1'b0;
          state <= DOWN;
        end
        DOWN: if (!hold && at_lo) begin
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else begin
            rem <= rem - 1'b1;
            dir <= 1'b1;
            state <= UP;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
